// File: rtl/conv_stream_engine_if.sv
// rtl/conv_stream_engine_if.sv - handshake bundle for conv_stream_engine
// Ports: kernel column stream (k_valid/k_data/k_ready), input column stream
// (a_valid/a_data/a_last/a_ready), result stream (out_valid/out_data/out_ready)
// and the short_err pulse. slave = engine side, master = feeder/sink side.
interface conv_stream_engine_if #(
  parameter int BW     = 8,
  parameter int ROWS   = 8,
  parameter int PSUM_W = 20
);
  logic                 k_valid;
  logic [ROWS*BW-1:0]   k_data;
  logic                 k_ready;
  logic                 a_valid;
  logic [ROWS*BW-1:0]   a_data;
  logic                 a_last;
  logic                 a_ready;
  logic                 out_valid;
  logic [PSUM_W-1:0]    out_data;
  logic                 out_ready;
  logic                 short_err;

  modport master (
    output k_valid, k_data, a_valid, a_data, a_last, out_ready,
    input  k_ready, a_ready, out_valid, out_data, short_err
  );

  modport slave (
    input  k_valid, k_data, a_valid, a_data, a_last, out_ready,
    output k_ready, a_ready, out_valid, out_data, short_err
  );
endinterface

// File: rtl/conv_stream_engine.sv
// rtl/conv_stream_engine.sv - streaming HEIGHT-tap column convolution engine
// Ports: clk, rst (async, active-high), s (conv_stream_engine_if.slave):
//   kernel columns in via k_*, input columns in via a_*, window dot products
//   out via out_*, short_err pulses when a sequence ends before a window fills.
// Optional feature: define CONV_SIGNED_EN for two's-complement elements;
// otherwise elements are unsigned.
module conv_stream_engine #(
  parameter int BW     = 8,
  parameter int ROWS   = 8,
  parameter int HEIGHT = 2,
  parameter int STRIDE = 1,
  parameter int PSUM_W = 2*BW + $clog2(ROWS*HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_stream_engine_if.slave   s
);
  localparam int CW = ROWS*BW;
  localparam int FW = $clog2(HEIGHT+1);
  localparam int PW = $clog2(STRIDE+1);

  localparam logic [0:0] LOAD_K = 1'b0;
  localparam logic [0:0] RUN    = 1'b1;

  logic [0:0]       state;
  logic [FW-1:0]    tap_cnt;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_nx;
  logic [PW-1:0]    phase;
  logic [CW-1:0]    kern   [HEIGHT];
  logic [CW-1:0]    win    [HEIGHT];
  logic [CW-1:0]    win_nx [HEIGHT];
  logic             k_fire;
  logic             a_fire;
  logic             full_nx;
  logic             emit;
  logic [PSUM_W-1:0] result;

  assign s.k_ready = (state == LOAD_K);
  // A new column may only be taken when the output register can absorb a result.
  assign s.a_ready = (state == RUN) && (!s.out_valid || s.out_ready);

  assign k_fire  = s.k_valid && s.k_ready;
  assign a_fire  = s.a_valid && s.a_ready;
  assign fill_nx = (fill == FW'(HEIGHT)) ? fill : fill + 1'b1;
  assign full_nx = (fill_nx == FW'(HEIGHT));
  assign emit    = a_fire && full_nx && (phase == '0);

  // Window as it will look after the incoming column shifts in (newest at top).
  always_comb begin
    for (int t = 0; t < HEIGHT - 1; t++) win_nx[t] = win[t+1];
    win_nx[HEIGHT-1] = s.a_data;
  end

  // Dot product of the shifted window against the kernel, computed on the
  // accept cycle so the result lands in the output register with the column.
  always_comb begin
    result = '0;
    for (int t = 0; t < HEIGHT; t++) begin
      for (int r = 0; r < ROWS; r++) begin
`ifdef CONV_SIGNED_EN
        result = result + PSUM_W'($signed(win_nx[t][r*BW +: BW]))
                        * PSUM_W'($signed(kern[t][r*BW +: BW]));
`else
        result = result + PSUM_W'(win_nx[t][r*BW +: BW])
                        * PSUM_W'(kern[t][r*BW +: BW]);
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD_K;
      tap_cnt     <= '0;
      fill        <= '0;
      phase       <= '0;
      for (int t = 0; t < HEIGHT; t++) begin
        kern[t] <= '0;
        win[t]  <= '0;
      end
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.short_err <= 1'b0;
    end else begin
      s.short_err <= 1'b0;

      if (k_fire) begin
        for (int t = 0; t < HEIGHT; t++)
          if (tap_cnt == FW'(t)) kern[t] <= s.k_data;
        if (tap_cnt == FW'(HEIGHT-1)) begin
          state   <= RUN;
          tap_cnt <= '0;
        end else begin
          tap_cnt <= tap_cnt + 1'b1;
        end
      end

      if (a_fire) begin
        for (int t = 0; t < HEIGHT; t++) win[t] <= win_nx[t];
        if (s.a_last) begin
          fill        <= '0;
          phase       <= '0;
          state       <= LOAD_K;
          s.short_err <= !full_nx;
        end else begin
          fill <= fill_nx;
          // Stride phase only runs once the window is full.
          if (full_nx) phase <= (phase == PW'(STRIDE-1)) ? '0 : phase + 1'b1;
        end
      end

      if (emit) begin
        s.out_data  <= result;
        s.out_valid <= 1'b1;
      end else if (s.out_valid && s.out_ready) begin
        s.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_stream_engine.sv
// tb/tb_conv_stream_engine.sv - self-checking bench for conv_stream_engine
// Ports exercised: clk, rst and both stream directions through two
// conv_stream_engine_if instances (STRIDE=1 and STRIDE=2 engines).
// Honours CONV_SIGNED_EN in its reference model.
module tb_conv_stream_engine;
  localparam int BW   = 8;
  localparam int ROWS = 8;
  localparam int H    = 2;
  localparam int PW   = 2*BW + $clog2(ROWS*H);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic sel = 1'b0;
  logic k_valid = 1'b0, a_valid = 1'b0, a_last = 1'b0, out_ready = 1'b0;
  logic [ROWS*BW-1:0] k_data = '0, a_data = '0;
  logic k_ready_o, a_ready_o, out_valid_o, short_err_o;
  logic [PW-1:0] out_data_o;

  int kern_m [H][ROWS];
  int col_m  [16][ROWS];
  logic [PW-1:0] first_res, last_res;
  int got_cnt, short_cnt;

  conv_stream_engine_if #(.BW(BW), .ROWS(ROWS), .PSUM_W(PW)) bus1 ();
  conv_stream_engine_if #(.BW(BW), .ROWS(ROWS), .PSUM_W(PW)) bus2 ();

  conv_stream_engine #(.BW(BW), .ROWS(ROWS), .HEIGHT(H), .STRIDE(1), .PSUM_W(PW))
    dut1 (.clk(clk), .rst(rst), .s(bus1));
  conv_stream_engine #(.BW(BW), .ROWS(ROWS), .HEIGHT(H), .STRIDE(2), .PSUM_W(PW))
    dut2 (.clk(clk), .rst(rst), .s(bus2));

  assign bus1.k_valid = k_valid;   assign bus2.k_valid = k_valid;
  assign bus1.k_data  = k_data;    assign bus2.k_data  = k_data;
  assign bus1.a_valid = a_valid;   assign bus2.a_valid = a_valid;
  assign bus1.a_data  = a_data;    assign bus2.a_data  = a_data;
  assign bus1.a_last  = a_last;    assign bus2.a_last  = a_last;
  assign bus1.out_ready = out_ready; assign bus2.out_ready = out_ready;

  assign k_ready_o   = sel ? bus2.k_ready   : bus1.k_ready;
  assign a_ready_o   = sel ? bus2.a_ready   : bus1.a_ready;
  assign out_valid_o = sel ? bus2.out_valid : bus1.out_valid;
  assign out_data_o  = sel ? bus2.out_data  : bus1.out_data;
  assign short_err_o = sel ? bus2.short_err : bus1.short_err;

  // Element value under the configured number format.
  function automatic longint val(input int v);
    logic [BW-1:0] b;
    b = BW'(v);
`ifdef CONV_SIGNED_EN
    return longint'($signed(b));
`else
    return longint'(b);
`endif
  endfunction

  // Dot product of columns start..start+H-1 against the kernel, wrapped to PW bits.
  function automatic logic [PW-1:0] window_sum(input int start);
    longint acc = 0;
    for (int t = 0; t < H; t++)
      for (int r = 0; r < ROWS; r++)
        acc += val(col_m[start+t][r]) * val(kern_m[t][r]);
    return acc[PW-1:0];
  endfunction

  function automatic logic [ROWS*BW-1:0] pack_k(input int t);
    logic [ROWS*BW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*BW +: BW] = BW'(kern_m[t][r]);
    return v;
  endfunction

  function automatic logic [ROWS*BW-1:0] pack_col(input int c);
    logic [ROWS*BW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*BW +: BW] = BW'(col_m[c][r]);
    return v;
  endfunction

  task automatic rand_data();
    for (int t = 0; t < H; t++)
      for (int r = 0; r < ROWS; r++) kern_m[t][r] = int'($urandom_range(0, 255));
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < ROWS; r++) col_m[c][r] = int'($urandom_range(0, 255));
  endtask

  task automatic fill_data(input int kv, input int av, input bit by_index);
    for (int t = 0; t < H; t++)
      for (int r = 0; r < ROWS; r++) kern_m[t][r] = kv;
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < ROWS; r++) col_m[c][r] = by_index ? c : av;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; k_valid = 1'b0; a_valid = 1'b0; a_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_kernel();
    int guard;
    for (int t = 0; t < H; t++) begin
      @(negedge clk);
      k_valid = 1'b1; k_data = pack_k(t); #1;
      guard = 0;
      while (!k_ready_o && guard < 50) begin @(negedge clk); #1; guard++; end
      total++;
      if (guard >= 50) begin bad++; $display("FAIL kload_timeout: tap %0d never accepted", t); end
      total++;
      if (a_ready_o !== 1'b0) begin bad++; $display("FAIL kload_a_ready: got %b exp 0", a_ready_o); end
    end
    @(negedge clk);
    k_valid = 1'b0; out_ready = 1'b1; #1;
    total++;
    if (k_ready_o !== 1'b0 || a_ready_o !== 1'b1) begin
      bad++; $display("FAIL run_entry: k_ready=%b a_ready=%b exp 0 1", k_ready_o, a_ready_o);
    end
  endtask

  // Streams n columns of col_m and checks every result, its latency, stall
  // behaviour, short_err and the return to kernel loading.
  task automatic stream(input int n, input int stride, input int rmode, input bit gaps);
    logic [PW-1:0] expv[$];
    logic [PW-1:0] prev_data = '0;
    int idx = 0, nout = 0, cyc = 0, hold = 0, new_w = 0, last_acc = -1;
    bit exp_new = 0, exp_short = 0, exp_load = 0, prev_hold = 0, acc_a, acc_o;
    for (int w = 0; w*stride + H <= n; w++) expv.push_back(window_sum(w*stride));
    first_res = '0; last_res = '0; short_cnt = 0;
    while ((idx < n || out_valid_o || exp_new || exp_short || exp_load || prev_hold) && cyc < 600) begin
      @(negedge clk);
      if (exp_new) begin
        total++;
        if (out_valid_o !== 1'b1 || out_data_o !== expv[new_w]) begin
          bad++; $display("FAIL latency w%0d: valid=%b data=%0d exp valid=1 data=%0d", new_w, out_valid_o, out_data_o, expv[new_w]);
        end
      end
      total++;
      if (short_err_o !== exp_short) begin bad++; $display("FAIL short_err: got %b exp %b", short_err_o, exp_short); end
      if (short_err_o === 1'b1) short_cnt++;
      if (exp_load) begin
        total++;
        if (k_ready_o !== 1'b1 || a_ready_o !== 1'b0) begin
          bad++; $display("FAIL back_to_load: k_ready=%b a_ready=%b exp 1 0", k_ready_o, a_ready_o);
        end
      end
      if (prev_hold) begin
        total++;
        if (out_valid_o !== 1'b1 || out_data_o !== prev_data) begin
          bad++; $display("FAIL hold: valid=%b data=%0d exp valid=1 data=%0d", out_valid_o, out_data_o, prev_data);
        end
      end
      if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (rmode == 2 && out_valid_o && hold < 10) begin out_ready = 1'b0; hold++; end
      else out_ready = 1'b1;
      a_valid = (idx < n) && (!gaps || $urandom_range(0, 3) != 0);
      if (idx < n) a_data = pack_col(idx);
      a_last = (idx == n - 1);
      #1;
      if (out_valid_o && !out_ready) begin
        total++;
        if (a_ready_o !== 1'b0) begin bad++; $display("FAIL stall_a_ready: got %b exp 0", a_ready_o); end
      end
      acc_a = a_valid && a_ready_o;
      acc_o = out_valid_o && out_ready;
      if (acc_o) begin
        total++;
        if (nout >= expv.size()) begin
          bad++; $display("FAIL extra_result: got %0d exp none", out_data_o);
        end else if (out_data_o !== expv[nout]) begin
          bad++; $display("FAIL result%0d: got %0d exp %0d", nout, out_data_o, expv[nout]);
        end
        if (nout == 0) first_res = out_data_o;
        last_res = out_data_o;
        nout++;
      end
      exp_new = 0; exp_short = 0; exp_load = 0;
      if (acc_a) begin
        if (idx >= H - 1 && (idx - (H - 1)) % stride == 0) begin exp_new = 1; new_w = (idx - (H - 1)) / stride; end
        if (idx == n - 1) begin exp_load = 1; exp_short = (n < H); end
        last_acc = cyc;
        idx++;
      end
      prev_hold = out_valid_o && !out_ready;
      prev_data = out_data_o;
      cyc++;
    end
    a_valid = 1'b0; a_last = 1'b0;
    total++;
    if (cyc >= 600) begin bad++; $display("FAIL stream_timeout: idx=%0d of %0d", idx, n); end
    total++;
    if (nout != expv.size()) begin bad++; $display("FAIL result_count: got %0d exp %0d", nout, expv.size()); end
    if (rmode == 0 && !gaps) begin
      total++;
      if (last_acc != n - 1) begin bad++; $display("FAIL throughput: last column at cycle %0d exp %0d", last_acc, n - 1); end
    end
    got_cnt = nout;
  endtask

  task automatic test_reset();
    rst = 1'b1; #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); #1;
      total++;
      if (k_ready_o !== 1'b1 || a_ready_o !== 1'b0 || out_valid_o !== 1'b0 || out_data_o !== '0 || short_err_o !== 1'b0) begin
        bad++; $display("FAIL reset_state dut%0d: k_ready=%b a_ready=%b out_valid=%b out_data=%0d short_err=%b exp 1 0 0 0 0",
                        s + 1, k_ready_o, a_ready_o, out_valid_o, out_data_o, short_err_o);
      end
    end
    sel = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    sel = 1'b0; do_reset(); fill_data(2, 1, 0);
    load_kernel(); stream(8, 1, 0, 0);
    total++;
    if (got_cnt != 7 || first_res !== PW'(32)) begin
      bad++; $display("FAIL basic: count=%0d first=%0d exp 7 32", got_cnt, first_res);
    end
  endtask

  task automatic test_stride();
    sel = 1'b1; do_reset(); fill_data(1, 0, 1);
    load_kernel(); stream(8, 2, 0, 0);
    total++;
    if (got_cnt != 4 || first_res !== PW'(8) || last_res !== PW'(104)) begin
      bad++; $display("FAIL stride: count=%0d first=%0d last=%0d exp 4 8 104", got_cnt, first_res, last_res);
    end
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] expf;
`ifdef CONV_SIGNED_EN
    expf = PW'(16);
`else
    expf = PW'(1040400);
`endif
    sel = 1'b0; do_reset(); fill_data(255, 255, 0);
    load_kernel(); stream(8, 1, 2, 0);
    total++;
    if (got_cnt != 7 || first_res !== expf) begin
      bad++; $display("FAIL backpressure: count=%0d first=%0d exp 7 %0d", got_cnt, first_res, expf);
    end
  endtask

  task automatic test_short();
    sel = 1'b0; do_reset(); rand_data();
    load_kernel(); stream(1, 1, 0, 0);
    total++;
    if (got_cnt != 0 || short_cnt != 1) begin
      bad++; $display("FAIL short_seq: results=%0d pulses=%0d exp 0 1", got_cnt, short_cnt);
    end
    @(negedge clk);
    total++;
    if (short_err_o !== 1'b0 || out_valid_o !== 1'b0) begin
      bad++; $display("FAIL short_pulse_len: short_err=%b out_valid=%b exp 0 0", short_err_o, out_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0; do_reset(); rand_data();
    load_kernel();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); a_valid = 1'b1; a_data = pack_col(c); a_last = 1'b0;
    end
    @(negedge clk); a_valid = 1'b0; out_ready = 1'b0; #1;
    total++;
    if (out_valid_o !== 1'b1) begin bad++; $display("FAIL mid_pending: out_valid=%b exp 1", out_valid_o); end
    #2 rst = 1'b1; #1;
    total++;
    if (k_ready_o !== 1'b1 || a_ready_o !== 1'b0 || out_valid_o !== 1'b0 || out_data_o !== '0 || short_err_o !== 1'b0) begin
      bad++; $display("FAIL mid_reset: k_ready=%b a_ready=%b out_valid=%b out_data=%0d short_err=%b exp 1 0 0 0 0",
                      k_ready_o, a_ready_o, out_valid_o, out_data_o, short_err_o);
    end
    @(negedge clk); rst = 1'b0;
    rand_data(); load_kernel(); stream(6, 1, 1, 1);
  endtask

  task automatic test_signed_data();
    logic [PW-1:0] expf;
`ifdef CONV_SIGNED_EN
    expf = 20'hFFFF0;
`else
    expf = PW'(4080);
`endif
    sel = 1'b0; do_reset(); fill_data(1, 255, 0);
    load_kernel(); stream(2, 1, 0, 0);
    total++;
    if (got_cnt != 1 || first_res !== expf) begin
      bad++; $display("FAIL signed_fmt: count=%0d data=%0h exp 1 %0h", got_cnt, first_res, expf);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); do_reset();
      for (int q = 0; q < 4; q++) begin
        rand_data(); n = int'($urandom_range(1, 12));
        load_kernel(); stream(n, s + 1, 1, 1);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stride();
    test_backpressure();
    test_short();
    test_reset_mid();
    test_signed_data();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_stream_engine.md
# conv_stream_engine

Streaming, parametrised successor to the fixed-size `conv_top` 1-D convolution datapath. It loads a HEIGHT-tap kernel column by column, then accepts a stream of ROWS-element input columns. For every HEIGHT-column window at the configured stride, it emits one partial sum through a valid/ready output register. It sits between the column feeder and the accumulation/writeback stage and replaces the whole-matrix parallel interface with handshaked streams.

## Interface
- `BW`, 8: element width in bits.
- `ROWS`, 8: elements per column.
- `HEIGHT`, 2: kernel taps (columns per window), must be ≥1.
- `STRIDE`, 1: column step between windows, must be ≥1.
- `PSUM_W`, 2*BW+$clog2(ROWS*HEIGHT): output width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `k_valid` in 1: kernel column valid.
- `k_data` in ROWS*BW: kernel column; row r at [r*BW +: BW].
- `k_ready` out 1: kernel column accepted when high with `k_valid`.
- `a_valid` in 1: input column valid.
- `a_data` in ROWS*BW: input column; same row packing as `k_data`.
- `a_last` in 1: marks the final column of a sequence.
- `a_ready` out 1: input column accepted when high with `a_valid`.
- `out_valid` out 1: result valid.
- `out_data` out PSUM_W: window dot product.
- `out_ready` in 1: downstream accepts result.
- `short_err` out 1: one-cycle pulse when a sequence ends before a window has filled.

## Operation
- FSM states:
  - LOAD_K: `k_ready`=1, `a_ready`=0. Each accepted kernel column is written to tap `tap_cnt`, then `tap_cnt` increments. When tap HEIGHT-1 is accepted, the FSM moves to RUN and `tap_cnt` clears.
  - RUN: `k_ready`=0 and `a_ready` = !out_valid || out_ready.
- On each accepted input column:
  - The column shifts into a HEIGHT-deep window register; the newest column aligns with tap HEIGHT-1 and the oldest with tap 0.
  - `fill` (saturating at HEIGHT) increments.
- A result is produced when the accepted column fills the window (fill reaches HEIGHT, including saturation) and `phase` = 0.
  - `phase` counts 0..STRIDE-1, wraps, and advances only on accepted columns after the window is full.
  - Result = Σ over taps t and rows r of win[t][r]·K[t][r], computed at full precision into PSUM_W.
  - Windows per sequence of N columns: floor((N−HEIGHT)/STRIDE)+1 if N ≥ HEIGHT, else 0.
- `a_last` accepted:
  - `fill` and `phase` clear and the FSM returns to LOAD_K; the next sequence needs a fresh kernel.
  - If `fill` < HEIGHT counting the last column, `short_err` pulses for one cycle and no result is produced.
- Output register behaviour:
  - Load: `out_data` <= result, `out_valid` <= 1.
  - Handshake without a new result: `out_valid` <= 0.
  - Handshake and new result in the same cycle: `out_data` replaced, `out_valid` stays 1.
  - `out_data` is held stable while out_valid && !out_ready.
- A pending output survives the RUN→LOAD_K transition and drains independently.

## Timing
- Reset values:
  - State LOAD_K; `tap_cnt`, `fill`, `phase` = 0; window and kernel registers = 0.
  - Outputs: `k_ready`=1, `a_ready`=0, `out_valid`=0, `out_data`=0, `short_err`=0.
- Kernel load takes HEIGHT handshake cycles minimum. `a_ready` may rise the cycle after the last kernel column is accepted.
- Latency: a column accepted at edge n gives `out_valid`=1 after edge n, visible in cycle n+1.
- Throughput: one column per cycle while `out_ready` is held high.
- `a_ready` depends combinationally on `out_ready`; there is no other combinational path from inputs to outputs.
- Reset mid-sequence discards the window, kernel and pending output. The FSM restarts in LOAD_K.

## Configuration
- `CONV_SIGNED_EN` defined: `a_data` and `k_data` elements are two's-complement, and products and the sum are signed and sign-extended to PSUM_W.
- Undefined: all elements are unsigned and the result is zero-extended.

## Test plan
- Parameters BW=8, ROWS=8, HEIGHT=2, STRIDE=1. Kernel all 2, 8 columns of all 1, `a_last` on column 8, `out_ready`=1. Expect 7 results, each 32, one per cycle starting one cycle after column 2 is accepted; FSM returns to LOAD_K.
- STRIDE=2, same data with column c holding all c (c = 0..7) and kernel all 1. Expect 4 results: 8, 40, 72, 104.
- All elements 255 (unsigned) → out_data = 1040400. Hold `out_ready`=0 → `a_ready` drops the cycle after the first result and `out_data` stays stable for 10 cycles. Release → the stream resumes with no loss or duplication.
- Single column with `a_last` → `short_err` pulses once, `out_valid` stays 0, `k_ready`=1 the next cycle.
- Assert `rst` after 3 columns with a result pending → all outputs are at reset values immediately. A new kernel and sequence then produce correct results.
- `CONV_SIGNED_EN` defined, A all 8'hFF, K all 1 → out_data = 20'hFFFF0 (−16). Undefined → 4080.
